// File: rtl/invaes_spi_sync.sv
// invaes_spi_sync: oversampled SPI slave front end for invaes_core.
// Define INVAES_LEN_CHECK_EN to reject frames that are not exactly FRAME_BITS long.
module invaes_spi_sync #(
  parameter int K          = 128,
  parameter int FRAME_BITS = 8 + K + 128
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           r_sclk,
  input  logic           r_mosi,
  input  logic           r_ce,
  output logic           r_miso,
  input  logic           done,
  input  logic [127:0]   plaintext,
  output logic           load,
  output logic [K-1:0]   key,
  output logic [127:0]   cyphertext,
  output logic [7:0]     dir_byte,
  output logic           frame_err,
  output logic           overrun
);

  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

`ifdef INVAES_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  if (K != 128 && K != 192 && K != 256) begin : g_bad_k
    $error("invaes_spi_sync: K must be 128, 192 or 256");
  end

  if (FRAME_BITS != 8 + K + 128) begin : g_bad_fb
    $error("invaes_spi_sync: FRAME_BITS is derived from K");
  end

  typedef enum logic [1:0] {
    IDLE,
    RX,
    BUSY,
    DONE
  } state_t;

  state_t state, state_d;

  logic [2:0] sclk_s;
  logic [2:0] ce_s;
  logic [1:0] mosi_s;
  logic       mosi_d;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       ce_rise;
  logic       ce_fall;
  logic       done_q;
  logic       done_rise;

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_sh;
  logic [FRAME_BITS-1:0] rx;
  logic [FRAME_BITS-1:0] rx_sh;
  logic [127:0]          tx;

  logic shift_in;
  logic frame_ok;
  logic start;
  logic accept;
  logic reject;
  logic set_ovr;
  logic latch_pt;

  // Two-flop synchronisers, third flop for edges, edge pulses registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s    <= '0;
      ce_s      <= '0;
      mosi_s    <= '0;
      mosi_d    <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      ce_rise   <= 1'b0;
      ce_fall   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sclk_s    <= {sclk_s[1:0], r_sclk};
      ce_s      <= {ce_s[1:0], r_ce};
      mosi_s    <= {mosi_s[0], r_mosi};
      mosi_d    <= mosi_s[1];
      sclk_rise <= sclk_s[1] & ~sclk_s[2];
      sclk_fall <= ~sclk_s[1] & sclk_s[2];
      ce_rise   <= ce_s[1] & ~ce_s[2];
      ce_fall   <= ~ce_s[1] & ce_s[2];
      done_q    <= done;
    end
  end

  assign done_rise = done & ~done_q;

  // A same-cycle sclk rise is folded in before the frame is judged.
  assign shift_in = sclk_rise && (state == RX);
  assign cnt_sh   = (shift_in && cnt != CNT_SAT) ? cnt + CW'(1) : cnt;
  assign rx_sh    = shift_in ? {rx[FRAME_BITS-2:0], mosi_d} : rx;
  assign frame_ok = LEN_CHECK ? (cnt_sh == CNT_FULL) : (cnt_sh != '0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state and control strobes.
  always_comb begin
    state_d  = state;
    start    = 1'b0;
    accept   = 1'b0;
    reject   = 1'b0;
    set_ovr  = 1'b0;
    latch_pt = 1'b0;
    unique case (state)
      IDLE: begin
        if (ce_rise) begin
          start   = 1'b1;
          state_d = RX;
        end
      end
      RX: begin
        if (ce_fall) begin
          if (frame_ok) begin
            accept  = 1'b1;
            state_d = BUSY;
          end else begin
            reject  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      BUSY: begin
        if (ce_rise) set_ovr = 1'b1;
        if (done_rise) begin
          latch_pt = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (ce_rise) begin
          start   = 1'b1;
          state_d = RX;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Receive shifter and bit counter, cleared at each frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      rx  <= '0;
    end else if (start) begin
      cnt <= '0;
      rx  <= '0;
    end else if (state == RX) begin
      cnt <= cnt_sh;
      rx  <= rx_sh;
    end
  end

  // Plaintext shift-out: first bit on frame start, then one per sclk fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx     <= '0;
      r_miso <= 1'b0;
    end else if (latch_pt) begin
      tx <= plaintext;
    end else if (start || (sclk_fall && state == RX)) begin
      r_miso <= tx[127];
      tx     <= {tx[126:0], 1'b0};
    end
  end

  // Field capture, load handshake and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      load       <= 1'b0;
      key        <= '0;
      cyphertext <= '0;
      dir_byte   <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (accept) begin
      load       <= 1'b1;
      dir_byte   <= rx_sh[FRAME_BITS-1 -: 8];
      key        <= rx_sh[K+127:128];
      cyphertext <= rx_sh[127:0];
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (start)   load      <= 1'b0;
      if (set_ovr) overrun   <= 1'b1;
      if (reject && LEN_CHECK) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_invaes_spi_sync.sv
// tb_invaes_spi_sync: scoreboard bench for invaes_spi_sync.
// Randomised SPI frames checked against a frame-level model.
module tb_invaes_spi_sync;

  localparam int K   = 128;
  localparam int FB  = 8 + K + 128;
  localparam int K2  = 256;
  localparam int FB2 = 8 + K2 + 128;

  logic           clk = 1'b0;
  logic           reset;
  logic           r_sclk, r_mosi, r_ce, r_ce2;
  logic           r_miso, r_miso2;
  logic           done, done2;
  logic [127:0]   plaintext, plaintext2;
  logic           load, load2;
  logic [K-1:0]   key;
  logic [K2-1:0]  key2;
  logic [127:0]   cyphertext, cyphertext2;
  logic [7:0]     dir_byte, dir_byte2;
  logic           frame_err, frame_err2;
  logic           overrun, overrun2;

  always #5 clk = ~clk;

  invaes_spi_sync dut (
    .clk(clk), .reset(reset),
    .r_sclk(r_sclk), .r_mosi(r_mosi), .r_ce(r_ce), .r_miso(r_miso),
    .done(done), .plaintext(plaintext),
    .load(load), .key(key), .cyphertext(cyphertext), .dir_byte(dir_byte),
    .frame_err(frame_err), .overrun(overrun)
  );

  invaes_spi_sync #(.K(K2)) dut2 (
    .clk(clk), .reset(reset),
    .r_sclk(r_sclk), .r_mosi(r_mosi), .r_ce(r_ce2), .r_miso(r_miso2),
    .done(done2), .plaintext(plaintext2),
    .load(load2), .key(key2), .cyphertext(cyphertext2), .dir_byte(dir_byte2),
    .frame_err(frame_err2), .overrun(overrun2)
  );

  typedef struct packed {
    logic [7:0]   dir;
    logic [K-1:0] key;
    logic [127:0] ct;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [127:0] m_tx;
  logic [K-1:0] m_key;
  logic [127:0] m_ct;
  logic [7:0]   m_dir;
  logic         m_ferr, m_ovr, m_load;
  int           m_phase;

  task automatic chk(input string name, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Each rising edge of load consumes one expected frame.
  initial begin : monitor
    exp_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (load === 1'b1 && prev == 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_load: got load with empty queue");
        end else begin
          e = exp_q.pop_front();
          if (key !== e.key || cyphertext !== e.ct || dir_byte !== e.dir) begin
            errors++;
            $display("FAIL sb_fields: got %0h %0h %0h want %0h %0h %0h",
                     dir_byte, key, cyphertext, e.dir, e.key, e.ct);
          end
        end
      end
      prev = (load === 1'b1);
    end
  end

  task automatic spi_xfer(input bit sel, input logic [511:0] bits,
                          input int n, input int hp, input bit coinc,
                          input int abort_at, output logic [511:0] mi,
                          output logic ld4);
    mi  = '0;
    ld4 = 1'b0;
    @(negedge clk);
    if (sel) r_ce2 = 1'b1;
    else     r_ce  = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) return;
      r_mosi = bits[n-1-i];
      repeat (hp) @(negedge clk);
      mi[n-1-i] = sel ? r_miso2 : r_miso;
      r_sclk = 1'b1;
      if (coinc && i == n - 1) begin
        r_ce  = 1'b0;
        r_ce2 = 1'b0;
      end else begin
        repeat (hp) @(negedge clk);
        r_sclk = 1'b0;
      end
    end
    if (!coinc) begin
      repeat (hp) @(negedge clk);
      r_ce  = 1'b0;
      r_ce2 = 1'b0;
    end
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (coinc && j == hp) r_sclk = 1'b0;
    end
    ld4 = sel ? load2 : load;
    r_sclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_load"}, load, m_load);
    chk({tag, "_ferr"}, frame_err, m_ferr);
    chk({tag, "_ovr"}, overrun, m_ovr);
    chk({tag, "_key"}, key, m_key);
    chk({tag, "_ct"}, cyphertext, m_ct);
    chk({tag, "_dir"}, dir_byte, m_dir);
  endtask

  task automatic frame(input string tag, input logic [511:0] bits,
                       input int n, input int hp, input bit coinc);
    logic [511:0] mi, m;
    logic [FB-1:0] f;
    logic ld4;
    exp_t e;
    bit acc, ign;
    ign = (m_phase == 1);
    m   = bits & ((512'(1) << n) - 512'(1));
    f   = m[FB-1:0];
`ifdef INVAES_LEN_CHECK_EN
    acc = !ign && (n == FB);
`else
    acc = !ign && (n >= 1);
`endif
    if (acc) begin
      e = {f[FB-1 -: 8], f[K+127:128], f[127:0]};
      exp_q.push_back(e);
    end
    spi_xfer(1'b0, m, n, hp, coinc, -1, mi, ld4);
    if (ign) begin
      m_ovr = 1'b1;
    end else begin
      if (hp >= 4) chk({tag, "_miso"}, mi, 512'(m_tx) << (n - 128));
      m_tx = '0;
      if (acc) begin
        m_dir   = f[FB-1 -: 8];
        m_key   = f[K+127:128];
        m_ct    = f[127:0];
        m_phase = 1;
        m_load  = 1'b1;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
      end else begin
        m_phase = 0;
        m_load  = 1'b0;
        m_ferr  = 1'b1;
      end
    end
    chk({tag, "_load_at4"}, ld4, m_load);
    check_outputs(tag);
  endtask

  task automatic pulse_done(input logic [127:0] pt);
    @(negedge clk);
    plaintext = pt;
    done = 1'b1;
    repeat (3) @(negedge clk);
    done = 1'b0;
    repeat (2) @(negedge clk);
    if (m_phase == 1) begin
      m_tx    = pt;
      m_phase = 2;
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    r_ce   = 1'b0;
    r_ce2  = 1'b0;
    r_sclk = 1'b0;
    r_mosi = 1'b0;
    repeat (4) @(negedge clk);
    reset   = 1'b0;
    m_tx    = '0;
    m_key   = '0;
    m_ct    = '0;
    m_dir   = '0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
    m_load  = 1'b0;
    m_phase = 0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [511:0] b, mi;
    logic ld4;
    int n, sel;
    done       = 1'b0;
    done2      = 1'b0;
    plaintext  = '0;
    plaintext2 = '0;
    do_reset();

    check_outputs("reset");
    chk("reset_miso", r_miso, 1'b0);

    b = '0;
    b[FB-1:0] = {8'h01, 128'h000102030405060708090a0b0c0d0e0f,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    frame("fips", b, FB, 5, 1'b0);
    pulse_done(128'h00112233445566778899aabbccddeeff);
    frame("miso", rnd512(), FB, 4, 1'b0);

    frame("overrun", rnd512(), FB, 4, 1'b0);
    pulse_done(rnd512()[127:0]);
    frame("short263", rnd512(), FB - 1, 4, 1'b0);

    for (int r = 0; r < 6; r++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       n = FB;
        1:       n = FB - 1;
        2:       n = FB + 1;
        default: n = $urandom_range(128, 300);
      endcase
      frame("rand", rnd512(), n, $urandom_range(4, 5), 1'b0);
      if ($urandom_range(0, 1) == 1) pulse_done(rnd512()[127:0]);
    end

    spi_xfer(1'b0, rnd512(), FB, 4, 1'b0, 100, mi, ld4);
    do_reset();
    check_outputs("abort");
    frame("post_reset", rnd512(), FB, 4, 1'b0);
    chk("post_reset_ferr", frame_err, 1'b0);

    pulse_done(rnd512()[127:0]);
    frame("coinc", rnd512(), FB, 2, 1'b1);
    chk("coinc_ferr", frame_err, 1'b0);

    b = '0;
    b[FB2-1:0] = {8'h5c, {32{8'ha5}}, 128'hfedcba98765432100123456789abcdef};
    spi_xfer(1'b1, b, FB2, 4, 1'b0, -1, mi, ld4);
    chk("k256_load", ld4, 1'b1);
    chk("k256_key", key2, {32{8'ha5}});
    chk("k256_ct", cyphertext2, 128'hfedcba98765432100123456789abcdef);
    chk("k256_dir", dir_byte2, 8'h5c);
    chk("k256_ferr", frame_err2, 1'b0);

    repeat (8) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
